ysyx_23060332_ifu: RTL and testbench
====================================

// Module: ysyx_23060332_ifu
// PURPOSE
//  Instruction fetch unit. Owns the PC and issues one fetch at a time over a valid/ready
//  instruction-memory interface. Hands each fetched instruction and its PC to the IDU via a
//  valid/ready handshake.
//  Takes the next-PC redirect (jump_en/jump_addr) that the EXU produces combinationally
//  from the instruction in hand-off.
// PARAMETERS
//  RESET_PC   32'h8000_0000   PC loaded on reset; first fetch address
//  ADDR_W     32              PC / fetch address width
//  DATA_W     32              instruction width
// PORTS
//  clk             in   1       core clock, all state on rising edge
//  rst             in   1       asynchronous, active-high reset
//  jump_en         in   1       EXU redirect request; sampled only on IDU hand-off
//  jump_addr       in   ADDR_W  EXU redirect target
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  fetch address (= current PC)
//  imem_rsp_valid  in   1       fetched instruction valid
//  imem_rsp_ready  out  1       IFU accepts response
//  imem_rsp_data   in   DATA_W  fetched instruction
//  inst_valid_o    out  1       instruction valid to IDU
//  inst_ready_i    in   1       IDU accepts instruction
//  inst_o          out  DATA_W  instruction to IDU
//  pc_o            out  ADDR_W  PC of inst_o
//  misalign_o      out  1       sticky misaligned-target flag (only with macro, see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any state incl. mid-transaction): state=S_REQ, pc=RESET_PC, inst_o=0,
//    inst_valid_o=0, imem_rsp_ready=0, misalign_o=0; imem_req_valid=1 from first cycle after release.
//  - FSM, one outstanding fetch max:
//    S_REQ : imem_req_valid=1, imem_req_addr=pc; req_valid & req_ready -> S_WAIT.
//            Addr held stable, valid not dropped, while ready=0.
//    S_WAIT: imem_rsp_ready=1; rsp_valid -> latch inst_o=imem_rsp_data -> S_HOLD.
//    S_HOLD: inst_valid_o=1, inst_o/pc_o stable until inst_ready_i.
//            On inst_valid_o & inst_ready_i (hand-off): pc <= jump_en ? jump_addr : pc+4,
//            then -> S_REQ.
//  - pc_o = pc in all states; pc changes only at hand-off or reset.
//  - jump_en/jump_addr ignored in any cycle without hand-off (no speculative fetch, nothing to kill).
//  - Responses with rsp_ready=0 (S_REQ/S_HOLD) are not consumed; memory must hold them.
//  - pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0), no flag.
//  - Latency: req accepted cycle N, rsp cycle N+1 earliest, inst_valid_o cycle N+2.
//    Back-to-back throughput 1 inst / 3 cycles with zero-wait memory and always-ready IDU.
//  - imem_req_valid, imem_rsp_ready, inst_valid_o are mutually exclusive, decoded from state only
//    (no combinational in->out path).
// CONFIGURATION
//  YSYX_23060332_IFU_MISALIGN_EN defined:
//    - hand-off with jump_en=1 and jump_addr[1:0]!=0 -> S_ERR, pc unchanged, misalign_o=1.
//    - In S_ERR, all valids/readies are 0 until reset.
//  Not defined:
//    - misalign_o tied 0; S_ERR absent; target used as jump_addr & ~3 (low bits cleared).
// TESTING
//  1 Reset release, req_ready=1, rsp 1 cycle later data=32'h0010_0093, inst_ready=1
//    -> req_addr=32'h8000_0000, inst_o=32'h0010_0093 with pc_o=32'h8000_0000, next req_addr=32'h8000_0004.
//  2 req_ready low 3 cycles, then high -> req_valid held, req_addr constant 32'h8000_0000 throughout.
//  3 inst_ready_i low 4 cycles in S_HOLD, jump_en pulses meanwhile
//    -> inst_o/pc_o stable, pulses ignored; hand-off with jump_en=0 -> next fetch 32'h8000_0004.
//  4 Hand-off with jump_en=1, jump_addr=32'h8000_0100 -> next imem_req_addr=32'h8000_0100.
//  5 Assert rst while in S_WAIT -> outputs return to reset values same cycle;
//    after release fetch restarts at 32'h8000_0000.
//  6 Hand-off with jump_en=1, jump_addr=32'h8000_0102:
//    with macro -> misalign_o=1, no further req_valid;
//    without macro -> next req_addr=32'h8000_0100.

Source files
------------

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC and runs one fetch at a time (request, response, hand-off to the IDU).
// Optional macro YSYX_23060332_IFU_MISALIGN_EN: a misaligned redirect traps into a sticky error state.
module ysyx_23060332_ifu #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   output logic              imem_rsp_ready,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              misalign_o
);

`ifdef YSYX_23060332_IFU_MISALIGN_EN
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_ERR  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;
`endif

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

   state_t            state_r;
   state_t            state_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_s;
   logic [DATA_W-1:0] inst_r;
   logic [DATA_W-1:0] inst_s;
   logic [ADDR_W-1:0] target_s;
   logic              misalign_r;
   logic              misalign_s;

   // Redirect targets are always word aligned; the low two bits never reach the PC.
   assign target_s = {jump_addr[ADDR_W-1:2], 2'b00};

`ifndef YSYX_23060332_IFU_MISALIGN_EN
   logic unused_s;
   assign unused_s = ^jump_addr[1:0];
`endif

   // State, PC, instruction and error flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_REQ;
         pc_r       <= RESET_PC;
         inst_r     <= {DATA_W{1'b0}};
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         inst_r     <= inst_s;
         misalign_r <= misalign_s;
      end
   end

   // Next-state logic; the PC moves only when the IDU takes the held instruction
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      inst_s     = inst_r;
      misalign_s = misalign_r;
      case (state_r)
         S_REQ: begin
            if (imem_req_ready) begin
               state_s = S_WAIT;
            end else begin
               state_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               inst_s  = imem_rsp_data;
               state_s = S_HOLD;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_HOLD: begin
            if (inst_ready_i) begin
`ifdef YSYX_23060332_IFU_MISALIGN_EN
               if (jump_en && (jump_addr[1:0] != 2'b00)) begin
                  misalign_s = 1'b1;
                  state_s    = S_ERR;
               end else if (jump_en) begin
                  pc_s    = target_s;
                  state_s = S_REQ;
               end else begin
                  pc_s    = pc_r + PC_STEP;
                  state_s = S_REQ;
               end
`else
               if (jump_en) begin
                  pc_s = target_s;
               end else begin
                  pc_s = pc_r + PC_STEP;
               end
               state_s = S_REQ;
`endif
            end else begin
               state_s = S_HOLD;
            end
         end
`ifdef YSYX_23060332_IFU_MISALIGN_EN
         S_ERR: begin
            state_s = S_ERR;
         end
`endif
         default: begin
            state_s = S_REQ;
         end
      endcase
   end

   // Handshake outputs decode the state register only, so no input reaches them combinationally.
   assign imem_req_valid = (state_r == S_REQ);
   assign imem_rsp_ready = (state_r == S_WAIT);
   assign inst_valid_o   = (state_r == S_HOLD);
   assign imem_req_addr  = pc_r;
   assign pc_o           = pc_r;
   assign inst_o         = inst_r;

`ifdef YSYX_23060332_IFU_MISALIGN_EN
   assign misalign_o = misalign_r;
`else
   assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Self-checking bench for ysyx_23060332_ifu: directed table, reset/misalign sequences, randomized fetch stream.
module tb_ysyx_23060332_ifu;

   logic        clk;
   logic        rst;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        misalign_o;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        jen;
      logic [31:0] jaddr;
      logic [31:0] data;
      int          req_wait;
      int          rsp_wait;
      int          hold_wait;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[6];

   ysyx_23060332_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .jump_en        (jump_en),
      .jump_addr      (jump_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid_o   (inst_valid_o),
      .inst_ready_i   (inst_ready_i),
      .inst_o         (inst_o),
      .pc_o           (pc_o),
      .misalign_o     (misalign_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // At most one of the three handshake strobes may be high in any cycle.
   always @(negedge clk) begin
      if (!rst) begin
         n_vec++;
         if ($countones({imem_req_valid, imem_rsp_ready, inst_valid_o}) > 1) begin
            n_err++;
            $display("FAIL strobes_exclusive: got %b%b%b expected at most one set",
                     imem_req_valid, imem_rsp_ready, inst_valid_o);
         end
      end
   end

   // One complete fetch: request (with stalls), response (with delay), hold (with IDU stalls), hand-off.
   task automatic do_txn(input logic [31:0] data, input int req_wait, input int rsp_wait,
                         input int hold_wait, input logic jen, input logic [31:0] jaddr,
                         input logic [31:0] exp_pc);
      int guard = 0;
      while (!imem_req_valid && guard < 10) begin
         tick();
         guard++;
      end
      chk("req_valid", 32'(imem_req_valid), 32'd1);
      chk("req_addr", imem_req_addr, exp_pc);
      chk("pc_o_in_req", pc_o, exp_pc);
      for (int i = 0; i < req_wait; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         tick();
         chk("req_valid_stall", 32'(imem_req_valid), 32'd1);
         chk("req_addr_stall", imem_req_addr, exp_pc);
      end
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      tick();
      imem_req_ready = 1'b0;
      chk("wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
      chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
      for (int i = 0; i < rsp_wait; i++) begin
         tick();
         chk("wait_rsp_ready_stall", 32'(imem_rsp_ready), 32'd1);
         chk("wait_inst_valid", 32'(inst_valid_o), 32'd0);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      chk("hold_inst_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_inst", inst_o, data);
      chk("hold_pc", pc_o, exp_pc);
      for (int i = 0; i < hold_wait; i++) begin
         inst_ready_i   = 1'b0;
         jump_en        = 1'(i % 2 == 0);
         jump_addr      = $urandom;
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = $urandom;
         tick();
         chk("hold_valid_stall", 32'(inst_valid_o), 32'd1);
         chk("hold_inst_stall", inst_o, data);
         chk("hold_pc_stall", pc_o, exp_pc);
      end
      imem_rsp_valid = 1'b0;
      inst_ready_i   = 1'b1;
      jump_en        = jen;
      jump_addr      = jaddr;
      tick();
      inst_ready_i   = 1'b0;
      jump_en        = 1'b0;
      jump_addr      = 32'h0;
   endtask

   initial begin
      logic [31:0] pc_m;
      logic [31:0] data;
      logic [31:0] jaddr;
      logic        jen;
      logic [31:0] pc_before;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'h0010_0093, 0, 0, 0, 32'h8000_0000};
      vecs[1] = '{1'b1, 32'h8000_0100, 32'h0020_0113, 0, 0, 0, 32'h8000_0004};
      vecs[2] = '{1'b0, 32'h0000_0000, 32'h0030_0193, 0, 0, 4, 32'h8000_0100};
      vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0040_0213, 0, 2, 1, 32'h8000_0104};
      vecs[4] = '{1'b0, 32'h0000_0000, 32'h0050_0293, 1, 0, 0, 32'hFFFF_FFFC};
      vecs[5] = '{1'b1, 32'h8000_0000, 32'h0060_0313, 2, 1, 2, 32'h0000_0000};

      rst            = 1'b1;
      jump_en        = 1'b0;
      jump_addr      = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      inst_ready_i   = 1'b0;

      tick();
      chk("rst_pc", pc_o, 32'h8000_0000);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      chk("rst_misalign", 32'(misalign_o), 32'd0);
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         do_txn(vecs[v].data, vecs[v].req_wait, vecs[v].rsp_wait, vecs[v].hold_wait,
                vecs[v].jen, vecs[v].jaddr, vecs[v].exp_pc);
      end

      // Reset asserted while a response is awaited.
      chk("pre_rst_req_addr", imem_req_addr, 32'h8000_0000);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("pre_rst_wait", 32'(imem_rsp_ready), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      chk("midrst_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("midrst_inst", inst_o, 32'h0);
      chk("midrst_pc", pc_o, 32'h8000_0000);
      chk("midrst_misalign", 32'(misalign_o), 32'd0);
      tick();
      rst = 1'b0;
      do_txn(32'h0070_0393, 3, 0, 0, 1'b0, 32'h0, 32'h8000_0000);
      pc_m = 32'h8000_0004;

      for (int n = 0; n < 150; n++) begin
         data  = $urandom;
         jen   = ($urandom_range(0, 3) == 0);
         jaddr = $urandom;
`ifdef YSYX_23060332_IFU_MISALIGN_EN
         jaddr[1:0] = 2'b00;
`endif
         do_txn(data, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                jen, jaddr, pc_m);
         pc_m = jen ? (jaddr & 32'hFFFF_FFFC) : (pc_m + 32'd4);
      end

      // Redirect to a target that is not word aligned.
      pc_before = pc_m;
      do_txn(32'h0080_0413, 0, 0, 0, 1'b1, 32'h8000_0102, pc_m);
`ifdef YSYX_23060332_IFU_MISALIGN_EN
      for (int i = 0; i < 3; i++) begin
         imem_req_ready = 1'b1;
         imem_rsp_valid = 1'b1;
         inst_ready_i   = 1'b1;
         tick();
         chk("err_misalign", 32'(misalign_o), 32'd1);
         chk("err_req_valid", 32'(imem_req_valid), 32'd0);
         chk("err_rsp_ready", 32'(imem_rsp_ready), 32'd0);
         chk("err_inst_valid", 32'(inst_valid_o), 32'd0);
         chk("err_pc", pc_o, pc_before);
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      inst_ready_i   = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err_cleared", 32'(misalign_o), 32'd0);
      do_txn(32'h0090_0493, 0, 0, 0, 1'b0, 32'h0, 32'h8000_0000);
`else
      chk("misalign_tied", 32'(misalign_o), 32'd0);
      do_txn(32'h0090_0493, 0, 0, 0, 1'b0, 32'h0, 32'h8000_0100);
      chk("after_misalign_pc", pc_o, 32'h8000_0104);
      chk("pc_before_differs", 32'(pc_before != 32'h8000_0100), 32'(pc_before != pc_o - 32'd4));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
